// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// One data-memory transaction per load/store, one writeback per instruction.
module mem_stage #(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic [2:0]           ex_funct3,
  input  logic [WIDTH-1:0]     ex_result,
  input  logic [WIDTH-1:0]     ex_rs2,
  input  logic [REG_WIDTH-1:0] ex_rd,
  input  logic                 ex_rd_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [WIDTH-1:0]     dmem_addr,
  output logic [WIDTH-1:0]     dmem_wdata,
  output logic [3:0]           dmem_wstrb,
  input  logic                 dmem_ack,
  input  logic [WIDTH-1:0]     dmem_rdata,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [REG_WIDTH-1:0] wb_rd,
  output logic [WIDTH-1:0]     wb_data,
  output logic                 mem_err
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t               state;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;
  logic [REG_WIDTH-1:0] rd_q;
  logic                 rd_we_q;

  logic                 is_mem;
  logic                 f3_ok;
  logic                 misal;
  logic                 err;
  logic [1:0]           a;
  logic [WIDTH-1:0]     st_wdata;
  logic [3:0]           st_wstrb;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [WIDTH-1:0]     ld_data;

  assign ex_ready = (state == IDLE);
  assign is_mem   = ex_is_load | ex_is_store;
  assign a        = ex_result[1:0];

  // Access legality: funct3 encoding, alignment and load/store conflict.
  always_comb begin
    f3_ok = 1'b0;
    misal = 1'b0;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ex_is_load & ~ex_is_store;
      default:                f3_ok = 1'b0;
    endcase
    case (ex_funct3[1:0])
      2'b01:   misal = a[0];
      2'b10:   misal = (a != 2'b00);
      default: misal = 1'b0;
    endcase
    err = (ex_is_load & ex_is_store) | (is_mem & (~f3_ok | misal));
  end

  // Store lane replication and byte strobes.
  always_comb begin
    st_wdata = ex_rs2;
    st_wstrb = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex_rs2[7:0]}};
        st_wstrb = 4'b0001 << a;
      end
      2'b01: begin
        st_wdata = {2{ex_rs2[15:0]}};
        st_wstrb = 4'b0011 << a;
      end
      default: begin
        st_wdata = ex_rs2;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // Control FSM with registered memory request and writeback record.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      mem_err    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (err) begin
              wb_valid <= 1'b1;
              mem_err  <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= ex_result;
            end else if (is_mem) begin
              state      <= MEM;
              f3_q       <= ex_funct3;
              off_q      <= a;
              rd_q       <= ex_rd;
              rd_we_q    <= ex_rd_we;
              dmem_req   <= 1'b1;
              dmem_we    <= ex_is_store;
              dmem_addr  <= {ex_result[WIDTH-1:2], 2'b00};
              dmem_wdata <= ex_is_store ? st_wdata : '0;
              dmem_wstrb <= ex_is_store ? st_wstrb : 4'b0000;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= ex_rd_we & (ex_rd != '0);
              wb_rd    <= ex_rd;
              wb_data  <= ex_result;
            end
          end
        end
        MEM: begin
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            if (dmem_we) begin
              wb_data <= '0;
            end else begin
              wb_we   <= rd_we_q & (rd_q != '0);
              wb_data <= ld_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage.
// Expected writebacks are queued at issue and popped by a monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        cd;
  } exp_t;

  exp_t sb[$];

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_result(ex_result), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void push(input logic we, input logic [4:0] rd,
                               input logic [31:0] d, input logic err,
                               input logic cd);
    exp_t e;
    e.we = we; e.rd = rd; e.data = d; e.err = err; e.cd = cd;
    sb.push_back(e);
  endfunction

  // Monitor: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_we", 32'(wb_we), 32'(e.we));
          chk("mem_err", 32'(mem_err), 32'(e.err));
          if (e.cd) begin
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            chk("wb_data", wb_data, e.data);
          end
        end
      end else if (mem_err) begin
        chk("err_without_wb", 32'(mem_err), 32'd0);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
  endtask

  task automatic set_ex(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rdwe);
    ex_is_load  = ld;
    ex_is_store = st;
    ex_funct3   = f3;
    ex_result   = res;
    ex_rs2      = rs2;
    ex_rd       = rd;
    ex_rd_we    = rdwe;
  endtask

  // Present one instruction and return #1 after the accepting edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rdwe);
    int n;
    @(posedge clk); #1;
    set_ex(ld, st, f3, res, rs2, rd, rdwe);
    ex_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ex_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ex_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input int dly,
                        input logic [31:0] rdata, input logic [31:0] e_addr,
                        input logic [31:0] e_wdata, input logic [3:0] e_strb);
    issue(ld, st, f3, addr, rs2, rd, 1'b1);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      chk("dmem_req", 32'(dmem_req), 32'd1);
      chk("ex_ready_mem", 32'(ex_ready), 32'd0);
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_we", 32'(dmem_we), 32'(st));
      chk("dmem_wstrb", 32'(dmem_wstrb), 32'(e_strb));
      if (st) chk("dmem_wdata", dmem_wdata, e_wdata);
      if (i == dly) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("dmem_req_drop", 32'(dmem_req), 32'd0);
  endtask

  task automatic err_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr);
    push(1'b0, 5'd4, 32'd0, 1'b1, 1'b0);
    issue(ld, st, f3, addr, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    chk("err_no_req", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    ex_valid   = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    set_ex(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    // Non-memory pass-through
    push(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    push(1'b0, 5'd0, 32'h0000_1234, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd0, 1'b1);
    push(1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd7, 1'b0);

    // Back-to-back non-memory ops
    push(1'b1, 5'd1, 32'h0000_0011, 1'b0, 1'b1);
    push(1'b1, 5'd2, 32'h0000_0022, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_ex(1'b0, 1'b0, 3'd0, 32'h11, 32'h0, 5'd1, 1'b1);
    ex_valid = 1'b1;
    @(posedge clk); #1;
    set_ex(1'b0, 1'b0, 3'd0, 32'h22, 32'h0, 5'd2, 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0;

    // Loads
    push(1'b1, 5'd6, 32'hFFFF_FF80, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 3,
           32'h80AA_BBCC, 32'h100, 32'h0, 4'b0000);
    push(1'b1, 5'd6, 32'h0000_0080, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd6, 1,
           32'h80AA_BBCC, 32'h100, 32'h0, 4'b0000);
    push(1'b1, 5'd7, 32'hFFFF_80AA, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 0,
           32'h80AA_BBCC, 32'h100, 32'h0, 4'b0000);
    push(1'b1, 5'd7, 32'h0000_80AA, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd7, 2,
           32'h80AA_BBCC, 32'h100, 32'h0, 4'b0000);
    push(1'b1, 5'd7, 32'hFFFF_BBCC, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 5'd7, 0,
           32'h80AA_BBCC, 32'h100, 32'h0, 4'b0000);
    push(1'b1, 5'd8, 32'h80AA_BBCC, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd8, 0,
           32'h80AA_BBCC, 32'h100, 32'h0, 4'b0000);
    push(1'b1, 5'd8, 32'hFFFF_FFCC, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 5'd8, 0,
           32'h80AA_BBCC, 32'h100, 32'h0, 4'b0000);
    push(1'b1, 5'd8, 32'h0000_00BB, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 5'd8, 1,
           32'h80AA_BBCC, 32'h100, 32'h0, 4'b0000);
    push(1'b0, 5'd0, 32'h80AA_BBCC, 1'b0, 1'b1);
    mem_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd0, 0,
           32'h80AA_BBCC, 32'h104, 32'h0, 4'b0000);

    // Stores
    push(1'b0, 5'd3, 32'h0, 1'b0, 1'b0);
    mem_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 2,
           32'h0, 32'h200, 32'hABCD_ABCD, 4'b1100);
    push(1'b0, 5'd3, 32'h0, 1'b0, 1'b0);
    mem_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_AB55, 5'd3, 0,
           32'h0, 32'h300, 32'h5555_5555, 4'b0010);
    push(1'b0, 5'd3, 32'h0, 1'b0, 1'b0);
    mem_op(1'b0, 1'b1, 3'b000, 32'h303, 32'h0000_007E, 5'd3, 1,
           32'h0, 32'h300, 32'h7E7E_7E7E, 4'b1000);
    push(1'b0, 5'd3, 32'h0, 1'b0, 1'b0);
    mem_op(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 5'd3, 1,
           32'h0, 32'h400, 32'hCAFE_F00D, 4'b1111);

    // Error accesses
    err_op(1'b1, 1'b0, 3'b010, 32'h101);
    err_op(1'b1, 1'b0, 3'b011, 32'h100);
    err_op(1'b1, 1'b1, 3'b010, 32'h100);
    err_op(1'b0, 1'b1, 3'b100, 32'h100);
    err_op(1'b0, 1'b1, 3'b001, 32'h203);
    err_op(1'b1, 1'b0, 3'b001, 32'h101);
    err_op(1'b1, 1'b0, 3'b010, 32'h102);
    err_op(1'b1, 1'b0, 3'b101, 32'h103);

    // Stall: next instruction waits while the load is outstanding
    push(1'b1, 5'd9, 32'h1122_3344, 1'b0, 1'b1);
    push(1'b1, 5'd10, 32'h0000_0077, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd9, 1'b1);
    set_ex(1'b0, 1'b0, 3'd0, 32'h77, 32'h0, 5'd10, 1'b1);
    ex_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(ex_ready), 32'd0);
      chk("stall_req", 32'(dmem_req), 32'd1);
      chk("stall_addr", dmem_addr, 32'h500);
      chk("stall_we", 32'(dmem_we), 32'd0);
      chk("stall_strb", 32'(dmem_wstrb), 32'd0);
      if (i == 9) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1122_3344;
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("stall_ready_after", 32'(ex_ready), 32'd1);
    chk("stall_req_after", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;

    // Reset while a request is outstanding, with a coincident ack
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd11, 1'b1);
    @(negedge clk);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    reset      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    reset    = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage placed directly downstream of `execute`. It takes the ALU result (effective address or plain result) and the `rs2` value. For loads and stores it performs one data-memory transaction over a req/ack handshake, applying byte-lane steering, sign/zero extension and alignment checks. It then presents one registered writeback record per accepted instruction to the register-file writeback port.

## Interface
- `WIDTH`, 32, datapath width; the byte-lane logic is defined for 32 only.
- `REG_WIDTH`, 5, register index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `ex_valid`  in  1  upstream instruction valid.
- `ex_ready`  out  1  stage can accept; transfer happens when `ex_valid && ex_ready`.
- `ex_is_load`  in  1  instruction is a load.
- `ex_is_store`  in  1  instruction is a store.
- `ex_funct3`  in  3  access size/sign field (RV32I encoding).
- `ex_result`  in  WIDTH  ALU result; this is the address for loads and stores.
- `ex_rs2`  in  WIDTH  store data.
- `ex_rd`  in  REG_WIDTH  destination register.
- `ex_rd_we`  in  1  instruction writes `rd`.
- `dmem_req`  out  1  memory request; held high until ack.
- `dmem_we`  out  1  1 = write, 0 = read.
- `dmem_addr`  out  WIDTH  word-aligned address (`[1:0]` = 0).
- `dmem_wdata`  out  WIDTH  lane-replicated store data.
- `dmem_wstrb`  out  4  byte-write strobes; 0 for reads.
- `dmem_ack`  in  1  transaction complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  WIDTH  read word.
- `wb_valid`  out  1  one-cycle writeback pulse.
- `wb_we`  out  1  register write enable; qualified by `wb_valid`.
- `wb_rd`  out  REG_WIDTH  writeback register.
- `wb_data`  out  WIDTH  writeback value.
- `mem_err`  out  1  one-cycle pulse for a misaligned or illegal access; coincides with its `wb_valid`.

## Operation

**FSM states:** IDLE, MEM.

**IDLE** (`ex_ready` = 1). Behaviour on a transfer:
- **Non-memory op** (neither load nor store):
  - Next cycle: `wb_valid`=1, `wb_data`=`ex_result`, `wb_rd`=`ex_rd`, `wb_we`=`ex_rd_we && ex_rd!=0`.
  - FSM stays in IDLE.
- **Legal, aligned load or store:**
  - Capture address, data, funct3 and rd; go to MEM.
- **Error access** (no memory request is issued):
  - Causes: `ex_is_load && ex_is_store`; illegal funct3; misalignment.
  - Next cycle: `wb_valid`=1, `wb_we`=0, `mem_err`=1. FSM stays in IDLE.

**Legal funct3 values:**
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.

**Misalignment:** half access with `addr[0]`=1; word access with `addr[1:0]`≠0.

**MEM** (`ex_ready` = 0):
- `dmem_req`=1. `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` are registered and stable until ack.
- On `dmem_ack`, go to IDLE.
  - Load: next cycle `wb_valid`=1 with formatted data, `wb_we`=`rd_we && rd!=0`.
  - Store: next cycle `wb_valid`=1, `wb_we`=0.

**Store steering** (`a` = `addr[1:0]`):
- SB: `wdata`={4{rs2[7:0]}}, `wstrb`=0001<<a.
- SH: `wdata`={2{rs2[15:0]}}, `wstrb`=0011<<a.
- SW: `wdata`=rs2, `wstrb`=1111.

**Load formatting:**
- Byte: select `rdata[8a+7:8a]`. Half: select `rdata[16a[1]+15:16a[1]]`.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

`dmem_ack` seen while in IDLE is ignored.

## Timing
- **Reset values:**
  - `ex_ready`=1 (combinational from IDLE).
  - `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_wstrb`=0.
  - `wb_valid`=0, `wb_we`=0, `wb_rd`=0, `wb_data`=0, `mem_err`=0.
  - FSM=IDLE.
- **Non-memory/error latency:** 1 cycle; back-to-back accepts give one writeback per cycle.
- **Memory path:**
  - Accept at cycle N; `dmem_req` high from N+1.
  - Ack at cycle M ≥ N+1; `wb_valid` at M+1; `dmem_req` low at M+1.
  - Earliest next accept is M+1.
- `wb_valid` and `mem_err` are single-cycle pulses, never held.
- **Reset mid-transaction:** the next edge forces IDLE and reset values. The request is dropped, no writeback is produced, and an ack arriving in the reset cycle is ignored.
- **Ack in the first MEM cycle** is legal; the total load path is then 2 cycles.
- There is no `wb` back-pressure; downstream always accepts.

## Test plan
- **ADD result passes through:** `ex_result`=0x0000_1234, rd=5, `rd_we`=1 → next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5, `wb_we`=1. Repeat with rd=0 → `wb_we`=0.
- **LB sign extension:** addr=0x103, ack after 3 cycles with `rdata`=0x80AA_BBCC → `dmem_addr`=0x100, `wstrb`=0, `wb_data`=0xFFFF_FF80 one cycle after ack. Same access as LBU → 0x0000_0080.
- **SH steering:** SH with addr=0x202, `rs2`=0x1234_ABCD → `dmem_we`=1, `dmem_addr`=0x200, `wdata`=0xABCD_ABCD, `wstrb`=1100; after ack `wb_valid`=1, `wb_we`=0.
- **Misaligned LW:** LW with addr=0x101 → no `dmem_req`; next cycle `wb_valid`=1, `mem_err`=1, `wb_we`=0. The same result is required for load funct3=011.
- **Stall:** load pending with ack withheld for 10 cycles and `ex_valid` held high → `ex_ready`=0 and `dmem_*` stable throughout; the next instruction is accepted the cycle after ack.
- **Reset during MEM:** assert `reset` for 1 cycle while `dmem_req`=1, with ack in the same cycle → all outputs reach reset values, no `wb_valid` is ever produced, and `ex_ready`=1 afterwards.
